// File: rtl/cnt_chk_pkg.sv
// Shared definitions for the counter sequence checker.
//   state_e  : checker FSM encoding (ST_IDLE / ST_ACQ / ST_LOCK)
//   DIR_DOWN : expected step is -1
//   DIR_UP   : expected step is +1
package cnt_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

  localparam int DIR_DOWN = 0;
  localparam int DIR_UP   = 1;

endpackage : cnt_chk_pkg

// File: rtl/cnt_step.sv
// Combinational one-step counter successor with natural modulo-2^WIDTH wrap.
// Ports:
//   v_i    in  WIDTH  current value
//   step_o out WIDTH  v_i - 1 (DIR = DIR_DOWN) or v_i + 1 (DIR = DIR_UP)
module cnt_step
  import cnt_chk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIR   = DIR_DOWN
) (
  input  logic [WIDTH-1:0] v_i,
  output logic [WIDTH-1:0] step_o
);

  always_comb begin
    if (DIR == DIR_UP) begin
      step_o = v_i + WIDTH'(1);
    end else begin
      step_o = v_i - WIDTH'(1);
    end
  end

endmodule : cnt_step

// File: rtl/count_seq_checker.sv
// Counter sequence checker: watches a counter bus and verifies every valid
// sample is exactly one step (DIR) from the previous one, modulo 2^WIDTH.
// Locks after LOCK_COUNT consecutive good steps; while locked, a bad step
// pulses err_pulse, bumps the saturating err_count and drops back to acquire.
// Optional feature macro: CNT_CHK_STICKY_EN adds the err_sticky output.
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous active-high reset (highest priority)
//   cnt_in     in   WIDTH      counter value under test
//   cnt_valid  in   1          qualifies cnt_in on a rising edge
//   locked     out  1          FSM is in ST_LOCK (registered)
//   expected   out  WIDTH      value required at the next valid sample
//   err_pulse  out  1          one-cycle pulse on a step error while locked
//   err_count  out  ERR_CNT_W  saturating step-error count
//   err_sticky out  1          (CNT_CHK_STICKY_EN only) set on first error, cleared by rst
module count_seq_checker
  import cnt_chk_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DIR        = DIR_DOWN,
  parameter int LOCK_COUNT = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     cnt_in,
  input  logic                 cnt_valid,
  output logic                 locked,
  output logic [WIDTH-1:0]     expected,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
`ifdef CNT_CHK_STICKY_EN
  ,
  output logic                 err_sticky
`endif
);

  localparam int MW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

  state_e                 state_q;
  logic [MW-1:0]          match_cnt_q;
  logic                   locked_q;
  logic [WIDTH-1:0]       expected_q;
  logic                   err_pulse_q;
  logic [ERR_CNT_W-1:0]   err_count_q;
  logic [WIDTH-1:0]       step_d;
  logic                   match;

  cnt_step #(
    .WIDTH (WIDTH),
    .DIR   (DIR)
  ) u_step (
    .v_i    (cnt_in),
    .step_o (step_d)
  );

  assign match = (cnt_in == expected_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      match_cnt_q <= '0;
      locked_q    <= 1'b0;
      expected_q  <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (cnt_valid) begin
        // Every valid sample re-seeds the prediction, whatever the state.
        expected_q <= step_d;
        unique case (state_q)
          ST_IDLE: begin
            match_cnt_q <= '0;
            state_q     <= ST_ACQ;
            locked_q    <= 1'b0;
          end
          ST_ACQ: begin
            if (match) begin
              match_cnt_q <= match_cnt_q + MW'(1);
              if (match_cnt_q + MW'(1) == MW'(LOCK_COUNT)) begin
                state_q  <= ST_LOCK;
                locked_q <= 1'b1;
              end
            end else begin
              match_cnt_q <= '0;
            end
          end
          ST_LOCK: begin
            if (!match) begin
              err_pulse_q <= 1'b1;
              if (err_count_q != '1) begin
                err_count_q <= err_count_q + ERR_CNT_W'(1);
              end
              match_cnt_q <= '0;
              state_q     <= ST_ACQ;
              locked_q    <= 1'b0;
            end
          end
          default: begin
            match_cnt_q <= '0;
            state_q     <= ST_IDLE;
            locked_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked    = locked_q;
  assign expected  = expected_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

`ifdef CNT_CHK_STICKY_EN
  logic err_sticky_q;

  // Set on the same edge that raises err_pulse, so both appear together.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
    end else if (cnt_valid && state_q == ST_LOCK && !match) begin
      err_sticky_q <= 1'b1;
    end
  end

  assign err_sticky = err_sticky_q;
`endif

endmodule : count_seq_checker

// File: tb/tb_count_seq_checker.sv
// Directed self-checking bench for count_seq_checker (WIDTH=4, DIR=down,
// LOCK_COUNT=2). A second instance with ERR_CNT_W=2 shares the stimulus and
// is used for the saturation check.
module tb_count_seq_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cnt_in = '0;
  logic       cnt_valid = 1'b0;

  logic       locked, err_pulse, locked2, err_pulse2;
  logic [3:0] expected, expected2;
  logic [7:0] err_count;
  logic [1:0] err_count2;
`ifdef CNT_CHK_STICKY_EN
  logic       err_sticky, err_sticky2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_seq_checker #(.WIDTH(4), .DIR(0), .LOCK_COUNT(2), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
    .locked(locked), .expected(expected), .err_pulse(err_pulse),
    .err_count(err_count)
`ifdef CNT_CHK_STICKY_EN
    , .err_sticky(err_sticky)
`endif
  );

  count_seq_checker #(.WIDTH(4), .DIR(0), .LOCK_COUNT(2), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
    .locked(locked2), .expected(expected2), .err_pulse(err_pulse2),
    .err_count(err_count2)
`ifdef CNT_CHK_STICKY_EN
    , .err_sticky(err_sticky2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one valid sample, let the edge take it, observe 1ns later.
  task automatic sample(input logic [3:0] v);
    @(negedge clk);
    cnt_valid = 1'b1;
    cnt_in    = v;
    @(posedge clk);
    #1;
    cnt_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    cnt_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cnt_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One lock followed by one error: 10,9,8 locks (expected 7), 3 is wrong.
  task automatic lock_then_error();
    sample(4'd10);
    sample(4'd9);
    sample(4'd8);
    chk("cyc_locked", {31'd0, locked}, 32'd1);
    sample(4'd3);
    chk("cyc_pulse", {31'd0, err_pulse}, 32'd1);
    chk("cyc_unlocked", {31'd0, locked}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_expected", {28'd0, expected}, 32'd0);
    chk("rst_pulse", {31'd0, err_pulse}, 32'd0);
    chk("rst_count", {24'd0, err_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1. acquire and lock
    sample(4'd15);
    chk("t1_s15_locked", {31'd0, locked}, 32'd0);
    chk("t1_s15_exp", {28'd0, expected}, 32'd14);
    sample(4'd14);
    chk("t1_s14_locked", {31'd0, locked}, 32'd0);
    sample(4'd13);
    chk("t1_s13_locked", {31'd0, locked}, 32'd1);
    sample(4'd12);
    chk("t1_s12_exp", {28'd0, expected}, 32'd11);
    chk("t1_count", {24'd0, err_count}, 32'd0);

    // 2. walk down to 2, then across the wrap
    for (int v = 11; v >= 2; v--) sample(4'(v));
    chk("t2_pre_exp", {28'd0, expected}, 32'd1);
    sample(4'd1);
    sample(4'd0);
    chk("t2_s0_exp", {28'd0, expected}, 32'd15);
    sample(4'd15);
    chk("t2_s15_pulse", {31'd0, err_pulse}, 32'd0);
    chk("t2_s15_locked", {31'd0, locked}, 32'd1);
    sample(4'd14);
    chk("t2_s14_exp", {28'd0, expected}, 32'd13);
    chk("t2_count", {24'd0, err_count}, 32'd0);

    // 3. error while locked, then relock
    for (int v = 13; v >= 9; v--) sample(4'(v));
    chk("t3_pre_exp", {28'd0, expected}, 32'd8);
    sample(4'd9);
    chk("t3_pulse", {31'd0, err_pulse}, 32'd1);
    chk("t3_count", {24'd0, err_count}, 32'd1);
    chk("t3_locked", {31'd0, locked}, 32'd0);
    chk("t3_exp", {28'd0, expected}, 32'd8);
`ifdef CNT_CHK_STICKY_EN
    chk("t3_sticky", {31'd0, err_sticky}, 32'd1);
`endif
    sample(4'd8);
    chk("t3_pulse_gone", {31'd0, err_pulse}, 32'd0);
    chk("t3_s8_locked", {31'd0, locked}, 32'd0);
    sample(4'd7);
    chk("t3_relocked", {31'd0, locked}, 32'd1);

    // 4. gap of 5 cycles is not an error
    sample(4'd6);
    sample(4'd5);
    sample(4'd4);
    for (int i = 0; i < 5; i++) begin
      idle_cycle();
      chk("t4_gap_locked", {31'd0, locked}, 32'd1);
      chk("t4_gap_exp", {28'd0, expected}, 32'd3);
      chk("t4_gap_pulse", {31'd0, err_pulse}, 32'd0);
    end
    sample(4'd3);
    chk("t4_after_pulse", {31'd0, err_pulse}, 32'd0);
    chk("t4_after_locked", {31'd0, locked}, 32'd1);
    chk("t4_after_exp", {28'd0, expected}, 32'd2);
    chk("t4_count", {24'd0, err_count}, 32'd1);

    // 5. saturation of a 2-bit error counter
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      lock_then_error();
      chk("t5_count8", {24'd0, err_count}, 32'(i));
      chk("t5_count2", {30'd0, err_count2}, (i > 3) ? 32'd3 : 32'(i));
    end

    // 6. reset wins over a bad sample
    do_reset();
`ifdef CNT_CHK_STICKY_EN
    chk("t6_sticky_cleared", {31'd0, err_sticky}, 32'd0);
`endif
    lock_then_error();
`ifdef CNT_CHK_STICKY_EN
    chk("t6_sticky_set", {31'd0, err_sticky}, 32'd1);
`endif
    lock_then_error();
    sample(4'd10);
    sample(4'd9);
    sample(4'd8);
    chk("t6_pre_locked", {31'd0, locked}, 32'd1);
    chk("t6_pre_count", {24'd0, err_count}, 32'd2);
    @(negedge clk);
    rst = 1'b1;
    cnt_valid = 1'b1;
    cnt_in = 4'd3;
    @(posedge clk);
    #1;
    chk("t6_locked", {31'd0, locked}, 32'd0);
    chk("t6_exp", {28'd0, expected}, 32'd0);
    chk("t6_pulse", {31'd0, err_pulse}, 32'd0);
    chk("t6_count", {24'd0, err_count}, 32'd0);
`ifdef CNT_CHK_STICKY_EN
    chk("t6_sticky", {31'd0, err_sticky}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    cnt_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_post_pulse", {31'd0, err_pulse}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_count_seq_checker
